dac_sequencer: RTL and testbench

DAC_SEQUENCER -- requirements
Module: dac_sequencer

---
 rtl/dac_sequencer.sv | 100 ++++++++++
 tb/tb_dac_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sequencer.sv
// dac_sequencer: per-channel shadow codes with pending bits, round-robin DAC word issue, settle and load phases
module dac_sequencer #(
  parameter int N_CH        = 8,
  parameter int CODE_W      = 12,
  parameter int SETTLE_CYC  = 16,
  parameter int REFRESH_CYC = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sw_wr,
  input  logic [3:0]               sw_ch,
  input  logic [CODE_W-1:0]        sw_code,
  input  logic                     update_all,
  output logic [23:0]              dac_word,
  output logic                     dac_valid,
  input  logic                     dac_ready,
  output logic                     busy,
  output logic                     err,
  output logic [N_CH*CODE_W-1:0]   shadow_rd
);
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  localparam int RW = REFRESH_CYC > 1 ? $clog2(REFRESH_CYC) : 1;
  localparam logic [4:0] NC = 5'(N_CH);
  typedef enum logic [2:0] {IDLE, SELECT, SEND, SETTLE, LOAD, LOAD_SETTLE} state_t;
  state_t state, nxt;
  logic [CODE_W-1:0] shadow [N_CH];
  logic [CODE_W-1:0] sel_code;
  logic [N_CH-1:0] pend, set_bits;
  logic [3:0] rr_ptr, cur_ch, sel_ch;
  logic [23:0] word_q;
  logic [SW-1:0] cnt;
  logic [RW-1:0] rtmr;
  logic wr_ok, refresh, any_pend, settled;
  assign wr_ok    = sw_wr && {1'b0, sw_ch} < NC;
  assign refresh  = REFRESH_CYC > 0 && rtmr == RW'(REFRESH_CYC - 1);
  assign any_pend = |pend;
  assign settled  = cnt == SW'(SETTLE_CYC - 1);
  for (genvar g = 0; g < N_CH; g++) begin : g_rd
    assign shadow_rd[g*CODE_W +: CODE_W] = shadow[g];
  end
  // pending bits raised this cycle by a software write, update_all or refresh
  always_comb begin
    set_bits = {N_CH{update_all || refresh}};
    for (int i = 0; i < N_CH; i++) if (wr_ok && sw_ch == 4'(i)) set_bits[i] = 1'b1;
  end
  // lowest pending channel at or above rr_ptr, otherwise lowest pending overall (wrap)
  always_comb begin
    sel_ch = '0;
    for (int j = N_CH - 1; j >= 0; j--) if (pend[j]) sel_ch = 4'(j);
    for (int j = N_CH - 1; j >= 0; j--) if (pend[j] && 4'(j) >= rr_ptr) sel_ch = 4'(j);
    sel_code = '0;
    for (int j = 0; j < N_CH; j++) if (sel_ch == 4'(j)) sel_code = shadow[j];
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  // next-state logic; a zero settle time skips the settle states entirely
  always_comb begin
    nxt = state;
    case (state)
      IDLE:        nxt = any_pend ? SELECT : IDLE;
      SELECT:      nxt = SEND;
      SEND:        nxt = !dac_ready ? SEND : SETTLE_CYC == 0 ? (any_pend ? SELECT : LOAD) : SETTLE;
      SETTLE:      nxt = !settled ? SETTLE : any_pend ? SELECT : LOAD;
      LOAD:        nxt = !dac_ready ? LOAD : SETTLE_CYC == 0 ? (any_pend ? SELECT : IDLE) : LOAD_SETTLE;
      LOAD_SETTLE: nxt = !settled ? LOAD_SETTLE : any_pend ? SELECT : IDLE;
      default:     nxt = IDLE;
    endcase
  end
  // outputs decoded from state so reset drops valid and busy asynchronously
  always_comb begin
    dac_valid = state == SEND || state == LOAD;
    busy      = state != IDLE;
    dac_word  = state == LOAD ? 24'h200000 : word_q;
  end
  // shadow codes, pending bits, latched word, round-robin pointer, timers and error pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
      pend   <= '0;
      rr_ptr <= '0;
      cur_ch <= '0;
      word_q <= '0;
      cnt    <= '0;
      rtmr   <= '0;
      err    <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) if (wr_ok && sw_ch == 4'(i)) shadow[i] <= sw_code;
      pend <= (state == SELECT ? pend & ~(N_CH'(1) << sel_ch) : pend) | set_bits;
      if (state == SELECT) begin
        cur_ch <= sel_ch;
        word_q <= {4'h0, sel_ch, 12'(sel_code) << (12 - CODE_W), 4'h0};
      end
      if (state == SEND && dac_ready) rr_ptr <= ({1'b0, cur_ch} + 5'd1 == NC) ? '0 : cur_ch + 4'd1;
      cnt  <= (state == SETTLE || state == LOAD_SETTLE) ? cnt + 1'b1 : '0;
      rtmr <= (REFRESH_CYC == 0 || refresh) ? '0 : rtmr + 1'b1;
      err  <= sw_wr && !wr_ok;
    end
endmodule

// File: tb/tb_dac_sequencer.sv
// tb_dac_sequencer: directed stimulus with a transaction-level expected-word queue and shadow model
module tb_dac_sequencer;
  logic clk = 1'b0, reset_n = 1'b0, sw_wr = 1'b0, update_all = 1'b0, dac_ready = 1'b1;
  logic [3:0] sw_ch = '0;
  logic [11:0] sw_code = '0;
  logic [23:0] dac_word;
  logic dac_valid, busy, err;
  logic [95:0] shadow_rd;
  int tests = 0, fails = 0;
  logic [23:0] exp_q[$];
  logic [11:0] m_shadow [8];
  logic [95:0] m_flat;
  logic exp_err = 1'b0, prev_valid = 1'b0, prev_acc = 1'b0;
  logic [23:0] prev_word = '0;
  int cyc = 0, last_acc = -1;

  dac_sequencer dut (
    .clk(clk), .reset_n(reset_n), .sw_wr(sw_wr), .sw_ch(sw_ch), .sw_code(sw_code),
    .update_all(update_all), .dac_word(dac_word), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .busy(busy), .err(err), .shadow_rd(shadow_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // compare process: outputs against the model on every falling edge
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 8; i++) m_flat[i*12 +: 12] = m_shadow[i];
    if (!reset_n) begin
      check("reset_outputs", {dac_valid, busy, err, dac_word}, 96'h0);
      check("reset_shadow", shadow_rd, 96'h0);
      exp_q.delete();
      for (int i = 0; i < 8; i++) m_shadow[i] = '0;
      exp_err = 1'b0;
      last_acc = -1;
      prev_valid = 1'b0;
      prev_acc = 1'b0;
    end else begin
      check("shadow_rd", shadow_rd, m_flat);
      check("err", err, exp_err);
      if (dac_valid) check("busy_when_valid", busy, 1'b1);
      if (prev_valid && !prev_acc) check("word_hold", {dac_valid, dac_word}, {1'b1, prev_word});
      if (dac_valid && !prev_valid && last_acc >= 0) begin
        tests++;
        if (cyc - last_acc < (dac_word[23:20] == 4'h2 ? 17 : 18)) begin
          fails++;
          $display("FAIL settle_gap: got %0d cycles before word %0h", cyc - last_acc, dac_word);
        end
      end
      if (dac_valid && dac_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected no transfer", dac_word);
        end else check("dac_word", dac_word, exp_q.pop_front());
        last_acc = cyc;
      end
      prev_valid = dac_valid;
      prev_acc = dac_valid && dac_ready;
      prev_word = dac_word;
      exp_err = sw_wr && sw_ch >= 4'd8;
      if (sw_wr && sw_ch < 4'd8) m_shadow[sw_ch[2:0]] = sw_code;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write(input int ch, input int code);
    sw_wr = 1'b1;
    sw_ch = 4'(ch);
    sw_code = 12'(code);
    tick();
    sw_wr = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!dac_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dac_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: got no dac_valid expected it within 50 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((busy || exp_q.size() != 0) && n < 1000);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_left"}, 96'(exp_q.size()), 96'h0);
    tick();
  endtask

  initial begin
    int n;
    logic bad;
    repeat (3) tick();
    check("rst_valid", dac_valid, 1'b0);
    check("rst_word", dac_word, 24'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_shadow", shadow_rd, 96'h0);
    reset_n = 1'b1;
    tick();
    // single write: latency, word, settle gap, load word
    exp_q.push_back(24'h03ABC0);
    exp_q.push_back(24'h200000);
    write(3, 'hABC);
    @(negedge clk);
    check("lat_pending", {dac_valid, busy}, 2'b00);
    @(negedge clk);
    check("lat_select", {dac_valid, busy}, 2'b01);
    @(negedge clk);
    check("lat_send", {dac_valid, dac_word}, {1'b1, 24'h03ABC0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dac_valid && n < 40);
    check("load_gap", 96'(n), 96'd17);
    check("load_word", dac_word, 24'h200000);
    wait_idle("t1_idle");
    check("t1_shadow", shadow_rd[47:36], 12'hABC);
    // backpressure: word held while ready low
    dac_ready = 1'b0;
    exp_q.push_back(24'h0155A0);
    exp_q.push_back(24'h200000);
    write(1, 'h55A);
    wait_valid("t2_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold", {dac_valid, dac_word}, {1'b1, 24'h0155A0});
    end
    tick();
    dac_ready = 1'b1;
    @(negedge clk);
    check("t2_accept", dac_valid, 1'b1);
    @(negedge clk);
    check("t2_done", dac_valid, 1'b0);
    wait_idle("t2_idle");
    // merged writes to ch5 while busy on ch0
    exp_q.push_back(24'h001000);
    exp_q.push_back(24'h053330);
    exp_q.push_back(24'h200000);
    write(0, 'h100);
    wait_valid("t3_valid");
    tick();
    write(5, 'h111);
    write(5, 'h222);
    write(5, 'h333);
    wait_idle("t3_idle");
    // out-of-range channel
    write(12, 'hFFF);
    @(negedge clk);
    check("t4_err_hi", err, 1'b1);
    @(negedge clk);
    check("t4_err_lo", err, 1'b0);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy || dac_valid) bad = 1'b1;
    end
    check("t4_no_traffic", bad, 1'b0);
    tick();
    // bring rr_ptr back to 0, then update_all with a simultaneous write to ch2
    exp_q.push_back(24'h077770);
    exp_q.push_back(24'h200000);
    write(7, 'h777);
    wait_idle("t5a_idle");
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(24'h001000);
    exp_q.push_back(24'h0155A0);
    exp_q.push_back(24'h022A20);
    exp_q.push_back(24'h03ABC0);
    exp_q.push_back(24'h040000);
    exp_q.push_back(24'h053330);
    exp_q.push_back(24'h060000);
    exp_q.push_back(24'h077770);
    exp_q.push_back(24'h200000);
    update_all = 1'b1;
    sw_wr = 1'b1;
    sw_ch = 4'd2;
    sw_code = 12'h2A2;
    tick();
    update_all = 1'b0;
    sw_wr = 1'b0;
    @(negedge clk);
    check("t5_pre_busy", busy, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (busy && n < 1000);
    check("t5_busy_through", 96'(exp_q.size()), 96'h0);
    tick();
    // write to the channel in SEND: word unchanged, channel rewritten
    dac_ready = 1'b0;
    exp_q.push_back(24'h044440);
    exp_q.push_back(24'h044A40);
    exp_q.push_back(24'h200000);
    write(4, 'h444);
    wait_valid("t6_valid");
    tick();
    write(4, 'h4A4);
    tick();
    check("t6_word_kept", dac_word, 24'h044440);
    dac_ready = 1'b1;
    wait_idle("t6_idle");
    check("t6_shadow", shadow_rd[59:48], 12'h4A4);
    // reset mid-SEND
    dac_ready = 1'b0;
    write(6, 'h666);
    wait_valid("t7_valid");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_async_drop", {dac_valid, busy}, 2'b00);
    tick();
    tick();
    reset_n = 1'b1;
    dac_ready = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy || dac_valid) bad = 1'b1;
    end
    check("t7_stays_idle", bad, 1'b0);
    check("t7_shadow", shadow_rd, 96'h0);
    check("end_queue", 96'(exp_q.size()), 96'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion by 500000 ns");
    $fatal(1, "watchdog");
  end
endmodule
